// File: rtl/pcm_receiver.sv
// PCM-over-Ethernet receiver: stores frame payloads in a commit/rewind sample FIFO and plays them out one sample set per pcm_stb.
// Optional build macro ETHERTYPE_CHECK_EN drops frames whose bytes 12-13 differ from ETHERTYPE.
module pcm_receiver #(
    parameter int          CHANNELS       = 8,
    parameter int          MAX_FRAME_SIZE = 1024,
    parameter int          NSAMPLES       = (MAX_FRAME_SIZE - 14) / (CHANNELS * 2),
    parameter int          FIFO_DEPTH     = 1024,
    parameter logic [15:0] ETHERTYPE      = 16'h88B5,
    localparam int         CW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int         PW             = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_sof,
    input  logic          rx_stb,
    input  logic [7:0]    rx_data,
    input  logic          rx_eof,
    input  logic          rx_err,
    input  logic          pcm_stb,
    output logic          out_stb,
    output logic [CW-1:0] out_chan,
    output logic [15:0]   out_data,
    output logic [PW-1:0] level,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   underrun_cnt
);
    localparam int AW        = PW - 1;
    localparam int FRAME_LEN = 14 + NSAMPLES * CHANNELS * 2;
    localparam int BW        = $clog2(FRAME_LEN + 1);
    localparam int CCW       = $clog2(CHANNELS + 1);

    localparam logic [BW-1:0]  HDR_LAST  = BW'(13);
    localparam logic [BW-1:0]  PAY_LAST  = BW'(FRAME_LEN - 1);
    localparam logic [PW-1:0]  DEPTH_P   = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0]  CHAN_P    = PW'(CHANNELS);
    localparam logic [CCW-1:0] CHAN_LAST = CCW'(CHANNELS);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, TAIL, DROP} rx_state_t;
    typedef enum logic [1:0] {WAIT, READ, EMIT} pl_state_t;

    rx_state_t      rx_state_q, rx_state_d;
    pl_state_t      pl_state_q, pl_state_d;
    logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]     lo_q, lo_d;
    logic [PW-1:0]  wr_sh_q, wr_sh_d;
    logic [PW-1:0]  wr_c_q, wr_c_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [CCW-1:0] ch_cnt_q, ch_cnt_d;
    logic           under_q, under_d;
    logic           out_stb_q, out_stb_d;
    logic [CW-1:0]  out_chan_q, out_chan_d;
    logic [15:0]    out_data_q, out_data_d;
    logic [15:0]    drop_q, drop_d;
    logic [15:0]    urun_q, urun_d;
    logic           mem_we;
    logic [PW-1:0]  avail;
    logic [15:0]    mem [FIFO_DEPTH];
`ifdef ETHERTYPE_CHECK_EN
    logic [7:0]     eth_hi_q, eth_hi_d;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rx_state_d = rx_state_q;
        byte_cnt_d = byte_cnt_q;
        lo_d       = lo_q;
        wr_sh_d    = wr_sh_q;
        wr_c_d     = wr_c_q;
        drop_d     = drop_q;
        mem_we     = 1'b0;
`ifdef ETHERTYPE_CHECK_EN
        eth_hi_d   = eth_hi_q;
`endif
        if (rx_sof) begin
            if ((rx_state_q == HDR || rx_state_q == PAYLOAD || rx_state_q == TAIL) && drop_q != 16'hFFFF)
                drop_d = drop_q + 16'd1;
            wr_sh_d    = wr_c_q;
            byte_cnt_d = '0;
            rx_state_d = HDR;
        end else if (rx_eof) begin
            // An eof in IDLE belongs to a frame already discarded by reset; it is not counted.
            if (rx_state_q == TAIL && !rx_err) begin
                wr_c_d = wr_sh_q;
            end else if (rx_state_q != IDLE) begin
                wr_sh_d = wr_c_q;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
            rx_state_d = IDLE;
        end else if (rx_stb) begin
            case (rx_state_q)
                HDR: begin
                    byte_cnt_d = byte_cnt_q + BW'(1);
`ifdef ETHERTYPE_CHECK_EN
                    if (byte_cnt_q == HDR_LAST - BW'(1)) eth_hi_d = rx_data;
                    if (byte_cnt_q == HDR_LAST)
                        rx_state_d = ({eth_hi_q, rx_data} == ETHERTYPE) ? PAYLOAD : DROP;
`else
                    if (byte_cnt_q == HDR_LAST) rx_state_d = PAYLOAD;
`endif
                end
                PAYLOAD: begin
                    byte_cnt_d = byte_cnt_q + BW'(1);
                    if (!byte_cnt_q[0]) begin
                        lo_d = rx_data;
                        if (byte_cnt_q == PAY_LAST) rx_state_d = TAIL;
                    end else if ((wr_sh_q - rd_q) >= DEPTH_P) begin
                        // Writing would overrun unread committed words.
                        rx_state_d = DROP;
                    end else begin
                        mem_we  = 1'b1;
                        wr_sh_d = wr_sh_q + PW'(1);
                        if (byte_cnt_q == PAY_LAST) rx_state_d = TAIL;
                    end
                end
                TAIL:    rx_state_d = DROP;
                default: ;
            endcase
        end
    end

    // Underrun decision includes a commit landing in the same cycle.
    assign avail = wr_c_d - rd_q;

    always_comb begin
        pl_state_d = pl_state_q;
        ch_cnt_d   = ch_cnt_q;
        rd_d       = rd_q;
        under_d    = under_q;
        urun_d     = urun_q;
        out_stb_d  = 1'b0;
        out_chan_d = '0;
        out_data_d = '0;
        case (pl_state_q)
            WAIT: begin
                if (pcm_stb) begin
                    under_d    = (avail < CHAN_P);
                    ch_cnt_d   = '0;
                    pl_state_d = READ;
                    if (avail < CHAN_P && urun_q != 16'hFFFF) urun_d = urun_q + 16'd1;
                end
            end
            default: begin
                if (pl_state_q == EMIT && ch_cnt_q == CHAN_LAST) begin
                    pl_state_d = WAIT;
                end else begin
                    out_stb_d  = 1'b1;
                    out_chan_d = CW'(ch_cnt_q);
                    ch_cnt_d   = ch_cnt_q + CCW'(1);
                    pl_state_d = EMIT;
                    if (!under_q) begin
                        out_data_d = mem[rd_q[AW-1:0]];
                        rd_d       = rd_q + PW'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= IDLE;
            pl_state_q <= WAIT;
            byte_cnt_q <= '0;
            lo_q       <= '0;
            wr_sh_q    <= '0;
            wr_c_q     <= '0;
            rd_q       <= '0;
            ch_cnt_q   <= '0;
            under_q    <= 1'b0;
            out_stb_q  <= 1'b0;
            out_chan_q <= '0;
            out_data_q <= '0;
            drop_q     <= '0;
            urun_q     <= '0;
`ifdef ETHERTYPE_CHECK_EN
            eth_hi_q   <= '0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            pl_state_q <= pl_state_d;
            byte_cnt_q <= byte_cnt_d;
            lo_q       <= lo_d;
            wr_sh_q    <= wr_sh_d;
            wr_c_q     <= wr_c_d;
            rd_q       <= rd_d;
            ch_cnt_q   <= ch_cnt_d;
            under_q    <= under_d;
            out_stb_q  <= out_stb_d;
            out_chan_q <= out_chan_d;
            out_data_q <= out_data_d;
            drop_q     <= drop_d;
            urun_q     <= urun_d;
`ifdef ETHERTYPE_CHECK_EN
            eth_hi_q   <= eth_hi_d;
`endif
        end
    end

    // NOTE: sample storage has no reset; pointers alone define which words are valid.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_sh_q[AW-1:0]] <= {rx_data, lo_q};
    end

    assign out_stb      = out_stb_q;
    assign out_chan     = out_chan_q;
    assign out_data     = out_data_q;
    assign level        = wr_c_q - rd_q;
    assign drop_cnt     = drop_q;
    assign underrun_cnt = urun_q;
endmodule

// File: tb/tb_pcm_receiver.sv
// Directed self-checking bench for pcm_receiver with default parameters (8 channels, 63 sets, 1022-byte frames).
module tb_pcm_receiver;
    localparam logic [15:0] ETH = 16'h88B5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_sof, rx_stb, rx_eof, rx_err, pcm_stb;
    logic [7:0]  rx_data;
    logic        out_stb;
    logic [2:0]  out_chan;
    logic [15:0] out_data;
    logic [10:0] level;
    logic [15:0] drop_cnt, underrun_cnt;

    int n_vec = 0;
    int n_err = 0;

    pcm_receiver dut (
        .clk(clk), .rst(rst), .rx_sof(rx_sof), .rx_stb(rx_stb), .rx_data(rx_data),
        .rx_eof(rx_eof), .rx_err(rx_err), .pcm_stb(pcm_stb), .out_stb(out_stb),
        .out_chan(out_chan), .out_data(out_data), .level(level), .drop_cnt(drop_cnt),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    // Frame byte b: header bytes 12/13 carry the ethertype, payload word k is (s<<4)|c.
    function automatic logic [7:0] fbyte(int b, logic [15:0] eth);
        logic [15:0] w;
        int k;
        if (b == 12) return eth[15:8];
        if (b == 13) return eth[7:0];
        if (b < 14 || b >= 1022) return 8'(b);
        k = (b - 14) / 2;
        w = 16'(((k / 8) << 4) | (k % 8));
        return ((b % 2) == 0) ? w[7:0] : w[15:8];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_bytes(int len, logic [15:0] eth);
        @(negedge clk);
        rx_sof = 1'b1;
        @(negedge clk);
        rx_sof = 1'b0;
        for (int b = 0; b < len; b++) begin
            rx_stb  = 1'b1;
            rx_data = fbyte(b, eth);
            @(negedge clk);
        end
        rx_stb  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic end_frame(logic err);
        rx_eof = 1'b1;
        rx_err = err;
        @(negedge clk);
        rx_eof = 1'b0;
        rx_err = 1'b0;
    endtask

    task automatic check_cnt(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raises pcm_stb at the current negedge and checks the full output window.
    task automatic play(logic under, int s);
        logic [15:0] exp;
        pcm_stb = 1'b1;
        @(negedge clk);
        pcm_stb = 1'b0;
        rx_eof  = 1'b0;
        rx_err  = 1'b0;
        n_vec++;
        if (out_stb !== 1'b0) begin
            n_err++;
            $display("FAIL play_t1 s=%0d: out_stb got %b expected 0", s, out_stb);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = under ? 16'h0000 : 16'((s << 4) | i);
            n_vec++;
            if (out_stb !== 1'b1 || out_chan !== 3'(i) || out_data !== exp) begin
                n_err++;
                $display("FAIL play s=%0d c=%0d: got stb=%b chan=%0d data=%h expected stb=1 chan=%0d data=%h",
                         s, i, out_stb, out_chan, out_data, i, exp);
            end
        end
        @(negedge clk);
        n_vec++;
        if (out_stb !== 1'b0 || out_chan !== 3'd0 || out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL play_end s=%0d: got stb=%b chan=%0d data=%h expected 0,0,0",
                     s, out_stb, out_chan, out_data);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({out_stb, out_chan, out_data, level, drop_cnt, underrun_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got stb=%b chan=%0d data=%h level=%0d drop=%0d urun=%0d expected all 0",
                     out_stb, out_chan, out_data, level, drop_cnt, underrun_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_underrun();
        do_reset();
        play(1'b1, 0);
        check_cnt("underrun_cnt", underrun_cnt, 16'd1);
        check_cnt("underrun_level", 16'(level), 16'd0);
    endtask

    task automatic test_good_frame();
        do_reset();
        send_bytes(1022, ETH);
        end_frame(1'b0);
        check_cnt("good_level", 16'(level), 16'd504);
        for (int s = 0; s < 63; s++) play(1'b0, s);
        check_cnt("good_level_end", 16'(level), 16'd0);
        check_cnt("good_drop", drop_cnt, 16'd0);
        check_cnt("good_urun", underrun_cnt, 16'd0);
    endtask

    task automatic test_drops();
        do_reset();
        send_bytes(1022, ETH);
        end_frame(1'b1);
        send_bytes(1021, ETH);
        end_frame(1'b0);
        send_bytes(1023, ETH);
        end_frame(1'b0);
        check_cnt("drops_cnt", drop_cnt, 16'd3);
        check_cnt("drops_level", 16'(level), 16'd0);
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            send_bytes(1022, ETH);
            end_frame(1'b0);
        end
        check_cnt("full_level", 16'(level), 16'd1008);
        check_cnt("full_drop", drop_cnt, 16'd1);
        for (int k = 0; k < 126; k++) play(1'b0, k % 63);
        check_cnt("full_level_end", 16'(level), 16'd0);
        check_cnt("full_urun", underrun_cnt, 16'd0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_bytes(300, ETH);
        send_bytes(1022, ETH);
        rx_eof = 1'b1;
        rx_err = 1'b0;
        play(1'b0, 0);
        check_cnt("b2b_drop", drop_cnt, 16'd1);
        check_cnt("b2b_level", 16'(level), 16'd496);
        check_cnt("b2b_urun", underrun_cnt, 16'd0);
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        @(negedge clk);
        rx_sof = 1'b1;
        @(negedge clk);
        rx_sof = 1'b0;
        for (int b = 0; b < 1022; b++) begin
            if (b == 100) rst = 1'b1;
            if (b == 102) rst = 1'b0;
            rx_stb  = 1'b1;
            rx_data = fbyte(b, ETH);
            @(negedge clk);
        end
        rx_stb = 1'b0;
        end_frame(1'b0);
        check_cnt("rstframe_drop", drop_cnt, 16'd0);
        check_cnt("rstframe_level", 16'(level), 16'd0);
        send_bytes(1022, ETH);
        end_frame(1'b0);
        check_cnt("rstframe_recover", 16'(level), 16'd504);
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        pcm_stb = 1'b1;
        @(negedge clk);
        pcm_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (out_stb !== 1'b1) begin
            n_err++;
            $display("FAIL rstplay_active: out_stb got %b expected 1", out_stb);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_stb !== 1'b0 || out_chan !== 3'd0 || underrun_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rstplay_stop: got stb=%b chan=%0d urun=%0d expected 0,0,0",
                     out_stb, out_chan, underrun_cnt);
        end
        rst = 1'b0;
    endtask

`ifdef ETHERTYPE_CHECK_EN
    task automatic test_ethertype();
        do_reset();
        send_bytes(1022, 16'h0800);
        end_frame(1'b0);
        check_cnt("eth_bad_drop", drop_cnt, 16'd1);
        check_cnt("eth_bad_level", 16'(level), 16'd0);
        send_bytes(1022, ETH);
        end_frame(1'b0);
        check_cnt("eth_good_level", 16'(level), 16'd504);
    endtask
`endif

    initial begin
        rst = 1'b1; rx_sof = 1'b0; rx_stb = 1'b0; rx_data = 8'h00;
        rx_eof = 1'b0; rx_err = 1'b0; pcm_stb = 1'b0;
        test_reset();
        test_underrun();
        test_good_frame();
        test_drops();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_mid_play();
`ifdef ETHERTYPE_CHECK_EN
        test_ethertype();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pcm_receiver.md
PCM_RECEIVER -- requirements
Module: pcm_receiver

Interface
REQ-001 The block SHALL have a parameter CHANNELS, default 8, giving the audio channels per sample set.
REQ-002 The block SHALL have a parameter MAX_FRAME_SIZE, default 1024, giving the maximum frame bytes.
REQ-003 The block SHALL have a parameter NSAMPLES, default (MAX_FRAME_SIZE-14)/(CHANNELS*2) = 63, giving the sample sets per frame.
REQ-004 The block SHALL have a parameter FIFO_DEPTH, default 1024, a power of two >= 2*NSAMPLES*CHANNELS, giving the 16-bit words of sample storage.
REQ-005 The block SHALL have a parameter ETHERTYPE, default 16'h88B5, used only under REQ-030.
REQ-006 The block SHALL have the ports below, in this order:
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- rx_sof  in  1  1-cycle pulse: new frame begins; next rx_stb carries byte 0
- rx_stb  in  1  rx_data valid this cycle
- rx_data  in  8  received byte
- rx_eof  in  1  1-cycle pulse after the last byte
- rx_err  in  1  sampled with rx_eof: FCS/PHY error
- pcm_stb  in  1  1-cycle playout tick, one per sample set
- out_stb  out  1  out_chan/out_data valid
- out_chan  out  clog2(CHANNELS)  channel index
- out_data  out  16  PCM sample
- level  out  clog2(FIFO_DEPTH)+1  committed words held
- drop_cnt  out  16  dropped frames, saturating
- underrun_cnt  out  16  underruns, saturating

Function
REQ-007 FRAME_LEN SHALL be 14 + NSAMPLES*CHANNELS*2 (1022 with defaults).
REQ-008 Bytes 0..13 SHALL be header; payload byte 14+2*(s*CHANNELS+c) SHALL be the low byte and the next byte the high byte of sample s, channel c.
REQ-009 The receive FSM SHALL have the states IDLE, HDR, PAYLOAD, TAIL and DROP; rx_sof SHALL go to HDR from any state, byte count 0.
REQ-010 After 14 header bytes, HDR SHALL go to PAYLOAD; each completed 16-bit word SHALL be written at a shadow write pointer, never at the committed pointer.
REQ-011 After FRAME_LEN bytes the FSM SHALL enter TAIL; any further rx_stb before rx_eof SHALL go to DROP.
REQ-012 On rx_eof in TAIL with rx_err=0, the shadow pointer SHALL become the committed pointer in the same cycle and the FSM SHALL go to IDLE.
REQ-013 On rx_eof in any other state, or with rx_err=1, the shadow pointer SHALL rewind to the committed pointer, drop_cnt SHALL increment, and the FSM SHALL go to IDLE.
REQ-014 rx_sof arriving while HDR, PAYLOAD or TAIL is active SHALL rewind the shadow pointer, increment drop_cnt once, and restart at HDR.
REQ-015 If the shadow write would make stored words exceed FIFO_DEPTH, the frame SHALL go to DROP; committed data SHALL stay intact.
REQ-016 In IDLE and DROP, rx_stb bytes SHALL be ignored.
REQ-017 The playout FSM SHALL have the states WAIT, READ and EMIT.
REQ-018 On pcm_stb in WAIT with level >= CHANNELS, the FSM SHALL read CHANNELS words.
REQ-019 For a pcm_stb at cycle T, out_stb SHALL be high in cycles T+2 .. T+1+CHANNELS, with out_chan = 0..CHANNELS-1 ascending.
REQ-020 Under REQ-019, out_data SHALL be the stored words in order, and level SHALL fall by CHANNELS.
REQ-021 On pcm_stb in WAIT with level < CHANNELS, the same out_stb timing SHALL occur with out_data=0, no words SHALL be popped, and underrun_cnt SHALL increment.
REQ-022 pcm_stb while in READ or EMIT SHALL be ignored.
REQ-023 A commit and a pop in the same cycle SHALL both apply; level SHALL equal the committed minus read pointer difference, mod 2*FIFO_DEPTH.
REQ-024 Pointers SHALL be clog2(FIFO_DEPTH)+1 bits wide, wrap naturally and address storage with their low bits.
REQ-025 Counters SHALL saturate at 16'hFFFF.
REQ-026 out_chan and out_data SHALL be 0 whenever out_stb=0.

Reset
REQ-027 While rst=1, both FSMs SHALL be in IDLE/WAIT, all pointers and counters SHALL be 0, and all outputs SHALL be 0.
REQ-028 Reset mid-frame SHALL discard the frame; bytes before the next rx_sof SHALL be ignored, and the discarded frame SHALL NOT count in drop_cnt.
REQ-029 Reset mid-playout SHALL end out_stb in the next cycle.

Configuration
REQ-030 With ETHERTYPE_CHECK_EN defined, bytes 12 (high) and 13 (low) not equal to ETHERTYPE SHALL send the frame to DROP at byte 13; without it, bytes 12-13 SHALL be ignored.

Verification
REQ-031 One good 1022-byte frame with word = (s<<4)|c, then 63 pcm_stb -> 504 out_stb with matching data and chan; level returns 0; counters 0.
REQ-032 pcm_stb with level 0 -> 8 zero samples at T+2..T+9; underrun_cnt=1; level stays 0.
REQ-033 Frame with rx_err=1 on rx_eof, then a 1021-byte frame, then a 1023-byte frame -> drop_cnt=3, level=0.
REQ-034 Three good frames with no playout -> frames 1-2 committed (level=1008), frame 3 dropped (drop_cnt=1); playout returns frames 1-2 intact.
REQ-035 rx_sof mid-payload followed by a good frame, with pcm_stb in the same cycle as rx_eof -> drop_cnt=1, commit and pop both apply, level=496.
REQ-036 With ETHERTYPE_CHECK_EN: bytes 12-13 = 08,00 -> dropped; 88,B5 -> committed.
